sort_sequencer: RTL and testbench

- Controller that sequences an in-place odd-even transposition sort over a NUM_WORDS-entry register file, using a row of compare-exchange `comparator` instances.
- Accepts words serially over a valid/ready stream, runs exactly NUM_WORDS sort phases, then drains the words in ascending order over a second stream.
- Sits between the upstream word source and downstream consumer of the sorting module.

---
 rtl/sort_sequencer_pkg.sv | 30 +++
 rtl/comparator.sv | 19 +
 rtl/sort_phase_row.sv | 61 ++++++
 rtl/sort_sequencer.sv | 122 ++++++++++++
 tb/tb_sort_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/sort_sequencer_pkg.sv
// Shared types and constants for the odd-even transposition sort sequencer.
package sort_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Largest register file the pair masks cover (ADR_WIDTH <= 6).
  localparam int unsigned MAX_WORDS = 64;

  localparam logic [MAX_WORDS-1:0] EVEN_MASK_FULL = {32{2'b01}};
  localparam logic [MAX_WORDS-1:0] ODD_MASK_FULL  = {32{2'b10}};

  function automatic int unsigned num_words(input int unsigned adr_width);
    return 32'(1) << adr_width;
  endfunction

  // Bit i set when entry i is the lower half of an active pair; the top entry never starts one.
  function automatic logic [MAX_WORDS-1:0] pair_mask(input int unsigned n, input logic odd);
    logic [MAX_WORDS-1:0] m;
    m = odd ? ODD_MASK_FULL : EVEN_MASK_FULL;
    for (int unsigned i = 0; i < MAX_WORDS; i++) begin
      if (i >= n - 1) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/comparator.sv
// Compare-exchange cell: when enabled, puts the smaller word on o_lo and the larger on o_hi.
module comparator #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_oen,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic [DATA_WIDTH-1:0] o_hi
);

  logic w_swap;

  // Equal words never swap, so duplicates keep their positions.
  assign w_swap = i_oen && (i_b < i_a);
  assign o_lo   = w_swap ? i_b : i_a;
  assign o_hi   = w_swap ? i_a : i_b;

endmodule

// File: rtl/sort_phase_row.sv
// One odd-even transposition phase over the whole register file (purely combinational).
module sort_phase_row
  import sort_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADR_WIDTH  = 3
) (
  input  logic                                        i_odd,
  input  logic [(2**ADR_WIDTH)-1:0][DATA_WIDTH-1:0]   i_words,
  output logic [(2**ADR_WIDTH)-1:0][DATA_WIDTH-1:0]   o_words
);

  localparam int unsigned NUM_WORDS = num_words(ADR_WIDTH);
  localparam int unsigned NUM_PAIRS = NUM_WORDS / 2;
  localparam logic [MAX_WORDS-1:0] EVEN_MASK = pair_mask(NUM_WORDS, 1'b0);
  localparam logic [MAX_WORDS-1:0] ODD_MASK  = pair_mask(NUM_WORDS, 1'b1);

  logic [NUM_WORDS-1:0]  w_mask;
  logic [DATA_WIDTH-1:0] w_a  [NUM_PAIRS];
  logic [DATA_WIDTH-1:0] w_b  [NUM_PAIRS];
  logic [DATA_WIDTH-1:0] w_lo [NUM_PAIRS];
  logic [DATA_WIDTH-1:0] w_hi [NUM_PAIRS];
  logic [NUM_PAIRS-1:0]  w_oen;

  assign w_mask = i_odd ? ODD_MASK[NUM_WORDS-1:0] : EVEN_MASK[NUM_WORDS-1:0];

  // Each cell serves pair (2k,2k+1) on even phases and (2k+1,2k+2) on odd phases.
  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
    localparam int unsigned ODD_HI = (k < NUM_PAIRS - 1) ? 2 * k + 2 : 2 * k + 1;

    assign w_a[k]   = i_odd ? i_words[2*k+1]  : i_words[2*k];
    assign w_b[k]   = i_odd ? i_words[ODD_HI] : i_words[2*k+1];
    assign w_oen[k] = i_odd ? w_mask[2*k+1]   : w_mask[2*k];

    comparator #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
      .i_oen (w_oen[k]),
      .i_a   (w_a[k]),
      .i_b   (w_b[k]),
      .o_lo  (w_lo[k]),
      .o_hi  (w_hi[k])
    );
  end

  always_comb begin
    o_words = i_words;
    if (i_odd) begin
      for (int unsigned k = 0; k + 1 < NUM_PAIRS; k++) begin
        o_words[2*k+1] = w_lo[k];
        o_words[2*k+2] = w_hi[k];
      end
    end else begin
      for (int unsigned k = 0; k < NUM_PAIRS; k++) begin
        o_words[2*k]   = w_lo[k];
        o_words[2*k+1] = w_hi[k];
      end
    end
  end

endmodule

// File: rtl/sort_sequencer.sv
// Loads a block of words, runs NUM_WORDS odd-even transposition phases, then drains ascending.
module sort_sequencer
  import sort_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned NUM_WORDS = num_words(ADR_WIDTH);
  localparam int unsigned CNT_W     = ADR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [CNT_W-1:0]                       r_cnt;
  logic [CNT_W-1:0]                       r_phase;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]   r_mem;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]   w_mem_sorted;
  logic [ADR_WIDTH-1:0]                   w_idx;
  logic                                   w_in_fire;
  logic                                   w_out_fire;
  logic                                   w_cnt_last;
  logic                                   w_phase_last;

  assign w_idx        = r_cnt[ADR_WIDTH-1:0];
  assign w_cnt_last   = (r_cnt == LAST_IDX);
  assign w_phase_last = (r_phase == LAST_IDX);
  assign w_in_fire    = in_valid && (r_state == ST_LOAD);
  assign w_out_fire   = out_ready && (r_state == ST_DRAIN);

  sort_phase_row #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADR_WIDTH  (ADR_WIDTH)
  ) u_row (
    .i_odd   (r_phase[0]),
    .i_words (r_mem),
    .o_words (w_mem_sorted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:  if (w_in_fire && w_cnt_last)  w_state_nxt = ST_SORT;
      ST_SORT:  if (w_phase_last)             w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_out_fire && w_cnt_last) w_state_nxt = ST_LOAD;
      default:                                w_state_nxt = ST_LOAD;
    endcase
  end

  // Outputs decode only registered state, so nothing depends combinationally on out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    case (r_state)
      ST_LOAD:  in_ready = 1'b1;
      ST_SORT:  busy = 1'b1;
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_mem[w_idx];
        out_last  = w_cnt_last;
      end
      default:  in_ready = 1'b0;
    endcase
  end

  // Word counter, phase counter and register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= '0;
      r_mem   <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_mem[w_idx] <= in_data;
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_phase <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_SORT: begin
          r_mem   <= w_mem_sorted;
          r_phase <= r_phase + CNT_W'(1);
          if (w_phase_last) r_cnt <= '0;
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            if (w_cnt_last) r_cnt <= '0;
            else            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: directed block table, stall/reset/back-to-back sequences, random blocks.
module tb_sort_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned N  = 8;

  typedef logic [DW-1:0]          word_t;
  typedef logic [N-1:0][DW-1:0]   blk_t;

  typedef struct packed {
    blk_t       din;
    blk_t       exp;
    logic [1:0] mode;
    logic       hold;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  logic  out_valid;
  logic  out_ready;
  word_t out_data;
  logic  out_last;
  logic  busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sort_sequencer #(
    .DATA_WIDTH (DW),
    .ADR_WIDTH  (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic blk_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    blk_t b;
    b[0] = word_t'(a0); b[1] = word_t'(a1); b[2] = word_t'(a2); b[3] = word_t'(a3);
    b[4] = word_t'(a4); b[5] = word_t'(a5); b[6] = word_t'(a6); b[7] = word_t'(a7);
    return b;
  endfunction

  // Reference: emit every value in increasing order as many times as it occurs.
  function automatic blk_t ref_sort(input blk_t a);
    blk_t s;
    int   k = 0;
    s = '0;
    for (int v = 0; v < (1 << DW); v++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (int'(a[i]) == v) begin
          s[k] = a[i];
          k++;
        end
      end
    end
    return s;
  endfunction

  task automatic load_block(input blk_t w, input logic hold, input word_t hold_data);
    for (int i = 0; i < int'(N); i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      check("in_ready_load", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = hold;
    in_data  = hold_data;
  endtask

  task automatic watch_sort();
    int cyc = 0;
    while (!out_valid && cyc < int'(4 * N)) begin
      check("busy_sort", 32'(busy), 32'd1);
      check("in_ready_sort", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("sort_latency", 32'(cyc), 32'(N));
  endtask

  task automatic drain_block(input blk_t exp, input logic [1:0] mode, input logic keep_valid);
    int idx = 0;
    int cyc = 0;
    while (idx < int'(N) && cyc < int'(8 * N)) begin
      case (mode)
        2'd0:    out_ready = 1'b1;
        2'd1:    out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", 32'(out_data), 32'(exp[idx]));
      check("out_last", 32'(out_last), 32'(idx == int'(N) - 1));
      check("busy_drain", 32'(busy), 32'd1);
      check("in_ready_drain", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
      if (out_ready) idx++;
    end
    check("drain_count", 32'(idx), 32'(N));
    out_ready = 1'b0;
    if (!keep_valid) in_valid = 1'b0;
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_after", 32'(out_valid), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic run_block(input blk_t din, input blk_t exp, input logic [1:0] mode, input logic hold);
    load_block(din, hold, 8'hEE);
    watch_sort();
    drain_block(exp, mode, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    blk_t b1, b2;

    tbl[0] = '{din: mk(7,6,5,4,3,2,1,0),         exp: mk(0,1,2,3,4,5,6,7),         mode: 2'd0, hold: 1'b0};
    tbl[1] = '{din: mk(3,3,0,255,1,3,0,128),     exp: mk(0,0,1,3,3,3,128,255),     mode: 2'd0, hold: 1'b0};
    tbl[2] = '{din: mk(0,1,2,3,4,5,6,7),         exp: mk(0,1,2,3,4,5,6,7),         mode: 2'd1, hold: 1'b1};
    tbl[3] = '{din: mk(200,17,17,90,4,255,0,17), exp: mk(0,4,17,17,17,90,200,255), mode: 2'd2, hold: 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) run_block(tbl[t].din, tbl[t].exp, tbl[t].mode, tbl[t].hold);

    // Reset while the sort is in phase 4 drops the block.
    load_block(mk(9,8,7,6,5,4,3,2), 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    check("busy_pre_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    run_block(mk(1,0,9,9,200,3,7,2), mk(0,1,2,3,7,9,9,200), 2'd0, 1'b0);

    // Back-to-back: next block's first word waits on in_valid through the whole drain.
    b1 = mk(50,40,30,20,10,60,70,0);
    b2 = mk(5,5,250,1,1,0,99,5);
    load_block(b1, 1'b1, b2[0]);
    watch_sort();
    drain_block(ref_sort(b1), 2'd2, 1'b1);
    load_block(b2, 1'b0, 8'h00);
    watch_sort();
    drain_block(ref_sort(b2), 2'd0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      blk_t  d;
      int    lim;
      lim = (r % 2 == 0) ? 255 : 3;
      for (int i = 0; i < int'(N); i++) d[i] = word_t'($urandom_range(0, lim));
      run_block(d, ref_sort(d), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
